// File: rtl/conv_wgrad_engine.sv
// conv_wgrad_engine
//   Integer convolution weight-gradient engine. For every weight it computes
//   dW[co][ci][kh][kw] (+)= sum(oh,ow) dy[co][oh][ow] * x[ci][oh*S+kh-P][ow*S+kw-P].
//   The sum is built in a local accumulator, and the weight is written back once.
//   Taps that land in the padding region are skipped without a memory read.
//   The engine has three word-addressed memory ports with a req/ack handshake.
// Ports
//   clk, rst_l             clock, asynchronous active-low reset
//   go / busy / done       start strobe, job-active flag, one-cycle end pulse
//   cfg                    {ci,co,h,w,kh,kw,oh,ow,stride,pad}, each DIMW bits
//   cfg_accum              1: add to the existing dW, 0: overwrite dW
//   base_x/base_dy/base_dw region base addresses
//   x_*/dy_*               read ports: req, addr, ack, rdata
//   dw_*                   read/write port: req, we, addr, wdata, ack, rdata
module conv_wgrad_engine #(
    parameter int DW   = 32,
    parameter int ACCW = 48,
    parameter int AW   = 32,
    parameter int DIMW = 16,
    parameter int SAT  = 1
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              go,
    output logic              busy,
    output logic              done,
    input  logic [10*DIMW-1:0] cfg,
    input  logic              cfg_accum,
    input  logic [AW-1:0]     base_x,
    input  logic [AW-1:0]     base_dy,
    input  logic [AW-1:0]     base_dw,
    output logic              x_req,
    output logic [AW-1:0]     x_addr,
    input  logic              x_ack,
    input  logic [DW-1:0]     x_rdata,
    output logic              dy_req,
    output logic [AW-1:0]     dy_addr,
    input  logic              dy_ack,
    input  logic [DW-1:0]     dy_rdata,
    output logic              dw_req,
    output logic              dw_we,
    output logic [AW-1:0]     dw_addr,
    output logic [DW-1:0]     dw_wdata,
    input  logic              dw_ack,
    input  logic [DW-1:0]     dw_rdata
);
    localparam int SW = DIMW + 2;

    typedef enum logic [3:0] {
        S_IDLE, S_SETUP, S_WINIT, S_TAP, S_LOAD, S_MAC, S_STEP, S_RD_DW, S_WR_DW, S_DONE
    } state_t;

    state_t state_reg, state_next;

    logic [DIMW-1:0] cfg_field [10];
    logic [DIMW-1:0] cfg_reg   [10];
    logic            accum_reg;
    logic [AW-1:0]   base_x_reg, base_dy_reg, base_dw_reg;
    logic [DIMW-1:0] ci_reg, co_reg, kh_reg, kw_reg, oh_reg, ow_reg;
    logic [ACCW-1:0] acc_reg;
    logic [DW-1:0]   x_data_reg, dy_data_reg;
    logic            x_req_reg, dy_req_reg, dw_req_reg, dw_we_reg;
    logic [AW-1:0]   x_addr_reg, dy_addr_reg, dw_addr_reg;
    logic [DW-1:0]   dw_wdata_reg;
    logic            x_got_reg, dy_got_reg;
    // Set once the request of the current LOAD/RD_DW/WR_DW visit is issued.
    logic            issued_reg;

    // Field 0 is the most significant slice of cfg (ci), field 9 is pad.
    genvar gi;
    for (gi = 0; gi < 10; gi++) begin : g_cfg
        assign cfg_field[gi] = cfg[(10-gi)*DIMW-1 -: DIMW];
    end

    logic [DIMW-1:0] c_ci, c_co, c_h, c_w, c_kh, c_kw, c_oh, c_ow, c_s, c_p;
    assign {c_ci, c_co, c_h, c_w, c_kh, c_kw} = {cfg_reg[0], cfg_reg[1], cfg_reg[2],
                                                  cfg_reg[3], cfg_reg[4], cfg_reg[5]};
    assign {c_oh, c_ow, c_s, c_p} = {cfg_reg[6], cfg_reg[7], cfg_reg[8], cfg_reg[9]};

    logic cfg_zero;
    assign cfg_zero = (c_ci == '0) || (c_co == '0) || (c_kh == '0) || (c_kw == '0) ||
                      (c_oh == '0) || (c_ow == '0);

    // Input coordinates in two's complement; a set sign bit means the tap
    // falls into the leading padding, so only the positive side needs a compare.
    logic [SW-1:0] ih_u, iw_u;
    logic          tap_oob;
    assign ih_u = SW'(oh_reg) * SW'(c_s) + SW'(kh_reg) - SW'(c_p);
    assign iw_u = SW'(ow_reg) * SW'(c_s) + SW'(kw_reg) - SW'(c_p);
    assign tap_oob = ih_u[SW-1] || (ih_u >= SW'(c_h)) || iw_u[SW-1] || (iw_u >= SW'(c_w));

    logic [AW-1:0] x_addr_c, dy_addr_c, dw_addr_c;
    assign x_addr_c  = base_x_reg + (AW'(ci_reg) * AW'(c_h) + AW'(ih_u[DIMW-1:0])) * AW'(c_w)
                       + AW'(iw_u[DIMW-1:0]);
    assign dy_addr_c = base_dy_reg + (AW'(co_reg) * AW'(c_oh) + AW'(oh_reg)) * AW'(c_ow)
                       + AW'(ow_reg);
    assign dw_addr_c = base_dw_reg + ((AW'(co_reg) * AW'(c_ci) + AW'(ci_reg)) * AW'(c_kh)
                       + AW'(kh_reg)) * AW'(c_kw) + AW'(kw_reg);

    logic ow_last, oh_last, kw_last, kh_last, ci_last, co_last, weight_last;
    assign ow_last = (ow_reg == c_ow - DIMW'(1));
    assign oh_last = (oh_reg == c_oh - DIMW'(1));
    assign kw_last = (kw_reg == c_kw - DIMW'(1));
    assign kh_last = (kh_reg == c_kh - DIMW'(1));
    assign ci_last = (ci_reg == c_ci - DIMW'(1));
    assign co_last = (co_reg == c_co - DIMW'(1));
    assign weight_last = kw_last && kh_last && ci_last && co_last;

    logic x_done, dy_done;
    assign x_done  = x_got_reg  || (x_req_reg  && x_ack);
    assign dy_done = dy_got_reg || (dy_req_reg && dy_ack);

    // Full-width signed product, sign-extended (or wrapped) into the accumulator.
    logic signed [2*DW-1:0] prod;
    logic [ACCW-1:0]        prod_ext, rd_ext;
    assign prod     = $signed(x_data_reg) * $signed(dy_data_reg);
    assign prod_ext = ACCW'(prod);
    assign rd_ext   = ACCW'($signed(dw_rdata));

    logic [DW-1:0] fmt_acc;
    if (SAT != 0 && ACCW > DW) begin : g_sat
        // In range exactly when all bits from DW-1 upward agree with the sign.
        logic [ACCW-DW:0] hi;
        assign hi = acc_reg[ACCW-1:DW-1];
        always_comb begin
            fmt_acc = acc_reg[DW-1:0];
            if (hi != '0 && hi != '1)
                fmt_acc = acc_reg[ACCW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end
    end else begin : g_wrap
        assign fmt_acc = acc_reg[DW-1:0];
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (go) state_next = S_SETUP;
            S_SETUP: state_next = cfg_zero ? S_DONE : S_WINIT;
            S_WINIT: state_next = S_TAP;
            S_TAP:   state_next = tap_oob ? S_STEP : S_LOAD;
            S_LOAD:  if (issued_reg && x_done && dy_done) state_next = S_MAC;
            S_MAC, S_STEP: begin
                if (ow_last && oh_last) state_next = accum_reg ? S_RD_DW : S_WR_DW;
                else                    state_next = S_TAP;
            end
            S_RD_DW: if (dw_req_reg && dw_ack) state_next = S_WR_DW;
            S_WR_DW: if (dw_req_reg && dw_ack) state_next = weight_last ? S_DONE : S_WINIT;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_reg <= S_IDLE;
            for (int i = 0; i < 10; i++) cfg_reg[i] <= '0;
            accum_reg <= 1'b0;
            {base_x_reg, base_dy_reg, base_dw_reg} <= '0;
            {ci_reg, co_reg, kh_reg, kw_reg, oh_reg, ow_reg} <= '0;
            acc_reg <= '0;
            {x_data_reg, dy_data_reg} <= '0;
            {x_req_reg, dy_req_reg, dw_req_reg, dw_we_reg} <= '0;
            {x_addr_reg, dy_addr_reg, dw_addr_reg} <= '0;
            dw_wdata_reg <= '0;
            {x_got_reg, dy_got_reg, issued_reg} <= '0;
        end else begin
            state_reg <= state_next;
            if (state_next != state_reg) issued_reg <= 1'b0;
            case (state_reg)
                S_IDLE: if (go) begin
                    for (int i = 0; i < 10; i++) cfg_reg[i] <= cfg_field[i];
                    accum_reg   <= cfg_accum;
                    base_x_reg  <= base_x;
                    base_dy_reg <= base_dy;
                    base_dw_reg <= base_dw;
                end
                S_SETUP: {ci_reg, co_reg, kh_reg, kw_reg} <= '0;
                S_WINIT: begin
                    acc_reg <= '0;
                    oh_reg  <= '0;
                    ow_reg  <= '0;
                end
                S_LOAD: begin
                    if (!issued_reg) begin
                        x_req_reg   <= 1'b1;
                        dy_req_reg  <= 1'b1;
                        x_addr_reg  <= x_addr_c;
                        dy_addr_reg <= dy_addr_c;
                        x_got_reg   <= 1'b0;
                        dy_got_reg  <= 1'b0;
                        issued_reg  <= 1'b1;
                    end else begin
                        if (x_req_reg && x_ack) begin
                            x_data_reg <= x_rdata;
                            x_req_reg  <= 1'b0;
                            x_got_reg  <= 1'b1;
                        end
                        if (dy_req_reg && dy_ack) begin
                            dy_data_reg <= dy_rdata;
                            dy_req_reg  <= 1'b0;
                            dy_got_reg  <= 1'b1;
                        end
                    end
                end
                S_MAC, S_STEP: begin
                    // MAC shares its cycle with the output-position step.
                    if (state_reg == S_MAC) acc_reg <= acc_reg + prod_ext;
                    if (ow_last) begin
                        ow_reg <= '0;
                        oh_reg <= oh_last ? '0 : oh_reg + DIMW'(1);
                    end else begin
                        ow_reg <= ow_reg + DIMW'(1);
                    end
                end
                S_RD_DW: begin
                    if (!issued_reg) begin
                        dw_req_reg  <= 1'b1;
                        dw_we_reg   <= 1'b0;
                        dw_addr_reg <= dw_addr_c;
                        issued_reg  <= 1'b1;
                    end else if (dw_req_reg && dw_ack) begin
                        dw_req_reg <= 1'b0;
                        acc_reg    <= acc_reg + rd_ext;
                    end
                end
                S_WR_DW: begin
                    if (!issued_reg) begin
                        dw_req_reg   <= 1'b1;
                        dw_we_reg    <= 1'b1;
                        dw_addr_reg  <= dw_addr_c;
                        dw_wdata_reg <= fmt_acc;
                        issued_reg   <= 1'b1;
                    end else if (dw_req_reg && dw_ack) begin
                        dw_req_reg <= 1'b0;
                        dw_we_reg  <= 1'b0;
                        // kw innermost, co outermost
                        if (!kw_last) kw_reg <= kw_reg + DIMW'(1);
                        else begin
                            kw_reg <= '0;
                            if (!kh_last) kh_reg <= kh_reg + DIMW'(1);
                            else begin
                                kh_reg <= '0;
                                if (!ci_last) ci_reg <= ci_reg + DIMW'(1);
                                else begin
                                    ci_reg <= '0;
                                    co_reg <= co_last ? '0 : co_reg + DIMW'(1);
                                end
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (state_reg != S_IDLE) && (state_reg != S_DONE);
    assign done     = (state_reg == S_DONE);
    assign x_req    = x_req_reg;
    assign x_addr   = x_addr_reg;
    assign dy_req   = dy_req_reg;
    assign dy_addr  = dy_addr_reg;
    assign dw_req   = dw_req_reg;
    assign dw_we    = dw_we_reg;
    assign dw_addr  = dw_addr_reg;
    assign dw_wdata = dw_wdata_reg;
endmodule

// File: tb/tb_conv_wgrad_engine.sv
// Testbench for conv_wgrad_engine: directed jobs against small memory models
// with configurable ack delay; one task per scenario.
module tb_conv_wgrad_engine;
    localparam int DW = 32, ACCW = 48, AW = 32, DIMW = 16;
    localparam int BX = 16, BDY = 64, BDW = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_l, go, busy, done, cfg_accum;
    logic [10*DIMW-1:0] cfg;
    logic [AW-1:0] base_x, base_dy, base_dw;
    logic x_req, x_ack, dy_req, dy_ack, dw_req, dw_we, dw_ack;
    logic [AW-1:0] x_addr, dy_addr, dw_addr;
    logic [DW-1:0] x_rdata, dy_rdata, dw_wdata, dw_rdata;

    conv_wgrad_engine #(.DW(DW), .ACCW(ACCW), .AW(AW), .DIMW(DIMW), .SAT(1)) dut (
        .clk(clk), .rst_l(rst_l), .go(go), .busy(busy), .done(done),
        .cfg(cfg), .cfg_accum(cfg_accum),
        .base_x(base_x), .base_dy(base_dy), .base_dw(base_dw),
        .x_req(x_req), .x_addr(x_addr), .x_ack(x_ack), .x_rdata(x_rdata),
        .dy_req(dy_req), .dy_addr(dy_addr), .dy_ack(dy_ack), .dy_rdata(dy_rdata),
        .dw_req(dw_req), .dw_we(dw_we), .dw_addr(dw_addr), .dw_wdata(dw_wdata),
        .dw_ack(dw_ack), .dw_rdata(dw_rdata)
    );

    logic [DW-1:0] xmem [256];
    logic [DW-1:0] dymem[256];
    logic [DW-1:0] dwmem[256];

    int total = 0, bad = 0;
    int max_delay = 0;
    int xreads = 0, dyreads = 0, dwreads = 0, dwwrites = 0;
    int stab_err = 0, xoob = 0, req_seen = 0;
    int x_lim = 255;

    task automatic clear_counts();
        xreads = 0; dyreads = 0; dwreads = 0; dwwrites = 0;
        stab_err = 0; xoob = 0; req_seen = 0;
    endtask

    // x memory responder
    initial begin : x_resp
        int cnt;
        logic waiting;
        logic [AW-1:0] held;
        cnt = 0; waiting = 1'b0; held = '0;
        x_ack = 1'b0; x_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_l || x_ack) begin
                x_ack = 1'b0; waiting = 1'b0;
            end else if (x_req) begin
                if (!waiting) begin
                    waiting = 1'b1; held = x_addr; req_seen++;
                    cnt = int'($urandom_range(max_delay, 0));
                    if (x_addr < AW'(BX) || x_addr > AW'(x_lim)) xoob++;
                end else if (x_addr !== held) stab_err++;
                if (cnt == 0) begin
                    x_ack = 1'b1; x_rdata = xmem[x_addr[7:0]]; xreads++;
                end else cnt--;
            end
        end
    end

    // dy memory responder
    initial begin : dy_resp
        int cnt;
        logic waiting;
        logic [AW-1:0] held;
        cnt = 0; waiting = 1'b0; held = '0;
        dy_ack = 1'b0; dy_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_l || dy_ack) begin
                dy_ack = 1'b0; waiting = 1'b0;
            end else if (dy_req) begin
                if (!waiting) begin
                    waiting = 1'b1; held = dy_addr; req_seen++;
                    cnt = int'($urandom_range(max_delay, 0));
                end else if (dy_addr !== held) stab_err++;
                if (cnt == 0) begin
                    dy_ack = 1'b1; dy_rdata = dymem[dy_addr[7:0]]; dyreads++;
                end else cnt--;
            end
        end
    end

    // dw memory responder (read and write)
    initial begin : dw_resp
        int cnt;
        logic waiting;
        logic [AW+DW:0] held;
        cnt = 0; waiting = 1'b0; held = '0;
        dw_ack = 1'b0; dw_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_l || dw_ack) begin
                dw_ack = 1'b0; waiting = 1'b0;
            end else if (dw_req) begin
                if (!waiting) begin
                    waiting = 1'b1; held = {dw_we, dw_addr, dw_wdata}; req_seen++;
                    cnt = int'($urandom_range(max_delay, 0));
                end else if ({dw_we, dw_addr, dw_wdata} !== held) stab_err++;
                if (cnt == 0) begin
                    dw_ack = 1'b1;
                    if (dw_we) begin
                        dwmem[dw_addr[7:0]] = dw_wdata; dwwrites++;
                    end else begin
                        dw_rdata = dwmem[dw_addr[7:0]]; dwreads++;
                    end
                end else cnt--;
            end
        end
    end

    // Start one job and wait (bounded) for done; cycles counts negedges after go.
    task automatic run_job(input int ci, co, h, w, kh, kw, oh, ow, s, p, input logic accum,
                           output int cycles, output logic timed_out);
        @(negedge clk);
        cfg = {DIMW'(ci), DIMW'(co), DIMW'(h), DIMW'(w), DIMW'(kh), DIMW'(kw),
               DIMW'(oh), DIMW'(ow), DIMW'(s), DIMW'(p)};
        cfg_accum = accum;
        go = 1'b1;
        cycles = 0;
        timed_out = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            cycles++;
            go = 1'b0;
            if (done) begin
                timed_out = 1'b0;
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic load_t1(input logic [DW-1:0] dw_init);
        for (int i = 0; i < 9; i++) xmem[BX+i] = DW'(i + 1);
        for (int i = 0; i < 4; i++) dymem[BDY+i] = 1;
        for (int i = 0; i < 9; i++) dwmem[BDW+i] = dw_init;
    endtask

    task automatic test_reset();
        logic [AW-1:0] a;
        rst_l = 1'b0; go = 1'b0; cfg = '0; cfg_accum = 1'b0;
        base_x = AW'(BX); base_dy = AW'(BDY); base_dw = AW'(BDW);
        repeat (3) @(negedge clk);
        if ({busy, done} !== 2'b00) begin
            $display("FAIL reset_status busy/done got=%b want=00", {busy, done}); bad++;
        end
        total++;
        if ({x_req, dy_req, dw_req, dw_we} !== 4'b0000) begin
            $display("FAIL reset_req got=%b want=0000", {x_req, dy_req, dw_req, dw_we}); bad++;
        end
        total++;
        a = x_addr | dy_addr | dw_addr;
        if (a !== '0 || dw_wdata !== '0) begin
            $display("FAIL reset_addr addr_or=%h wdata=%h want 0", a, dw_wdata); bad++;
        end
        total++;
        rst_l = 1'b1;
        @(negedge clk);
        $display("test_reset checked");
    endtask

    task automatic test_basic();
        int cyc; logic to;
        int exp[4] = '{12, 16, 24, 28};
        load_t1(32'hDEAD); clear_counts(); max_delay = 0;
        run_job(1, 1, 3, 3, 2, 2, 2, 2, 1, 0, 1'b0, cyc, to);
        if (to !== 1'b0) begin $display("FAIL basic_timeout got=%b want=0", to); bad++; end
        total++;
        for (int i = 0; i < 4; i++) begin
            if (dwmem[BDW+i] !== DW'(exp[i])) begin
                $display("FAIL basic_dw[%0d] got=%0d want=%0d", i, dwmem[BDW+i], exp[i]); bad++;
            end
            total++;
        end
        if (xreads !== 16 || dyreads !== 16) begin
            $display("FAIL basic_reads x=%0d dy=%0d want 16/16", xreads, dyreads); bad++;
        end
        total++;
        if (dwwrites !== 4 || dwreads !== 0) begin
            $display("FAIL basic_dw_access wr=%0d rd=%0d want 4/0", dwwrites, dwreads); bad++;
        end
        total++;
        $display("test_basic job done in %0d cycles", cyc);
    endtask

    task automatic test_accum();
        int cyc; logic to;
        int exp[4] = '{112, 116, 124, 128};
        load_t1(100); clear_counts();
        run_job(1, 1, 3, 3, 2, 2, 2, 2, 1, 0, 1'b1, cyc, to);
        if (to !== 1'b0) begin $display("FAIL accum_timeout got=%b want=0", to); bad++; end
        total++;
        for (int i = 0; i < 4; i++) begin
            if (dwmem[BDW+i] !== DW'(exp[i])) begin
                $display("FAIL accum_dw[%0d] got=%0d want=%0d", i, dwmem[BDW+i], exp[i]); bad++;
            end
            total++;
        end
        if (dwreads !== 4 || dwwrites !== 4) begin
            $display("FAIL accum_dw_access rd=%0d wr=%0d want 4/4", dwreads, dwwrites); bad++;
        end
        total++;
        $display("test_accum job done in %0d cycles", cyc);
    endtask

    task automatic test_pad_stride();
        int cyc; logic to;
        int exp[9] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
        for (int i = 0; i < 9; i++) begin xmem[BX+i] = 1; dwmem[BDW+i] = 32'hBAD; end
        for (int i = 0; i < 4; i++) dymem[BDY+i] = 1;
        clear_counts(); x_lim = BX + 8;
        run_job(1, 1, 3, 3, 3, 3, 2, 2, 2, 1, 1'b0, cyc, to);
        x_lim = 255;
        if (to !== 1'b0) begin $display("FAIL pad_timeout got=%b want=0", to); bad++; end
        total++;
        for (int i = 0; i < 9; i++) begin
            if (dwmem[BDW+i] !== DW'(exp[i])) begin
                $display("FAIL pad_dw[%0d] got=%0d want=%0d", i, dwmem[BDW+i], exp[i]); bad++;
            end
            total++;
        end
        if (xoob !== 0 || xreads !== 16) begin
            $display("FAIL pad_xreads oob=%0d reads=%0d want 0/16", xoob, xreads); bad++;
        end
        total++;
        $display("test_pad_stride job done in %0d cycles", cyc);
    endtask

    task automatic test_random_ack();
        int cyc; logic to;
        int exp[4] = '{12, 16, 24, 28};
        load_t1(0); clear_counts(); max_delay = 7;
        run_job(1, 1, 3, 3, 2, 2, 2, 2, 1, 0, 1'b0, cyc, to);
        max_delay = 0;
        if (to !== 1'b0) begin $display("FAIL rand_timeout got=%b want=0", to); bad++; end
        total++;
        for (int i = 0; i < 4; i++) begin
            if (dwmem[BDW+i] !== DW'(exp[i])) begin
                $display("FAIL rand_dw[%0d] got=%0d want=%0d", i, dwmem[BDW+i], exp[i]); bad++;
            end
            total++;
        end
        if (stab_err !== 0 || xreads !== 16 || dwwrites !== 4) begin
            $display("FAIL rand_handshake stab=%0d xrd=%0d wr=%0d want 0/16/4",
                     stab_err, xreads, dwwrites); bad++;
        end
        total++;
        $display("test_random_ack job done in %0d cycles", cyc);
    endtask

    task automatic test_saturate();
        int cyc; logic to;
        logic [DW-1:0] xv[3]  = '{32'h0000FFFF, 32'h0000FFFF, 32'hFFFFFFFD};
        logic [DW-1:0] dyv[3] = '{32'h0000FFFF, 32'hFFFF0001, 32'h00000005};
        logic [DW-1:0] ev[3]  = '{32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFC4};
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 4; i++) begin xmem[BX+i] = xv[k]; dymem[BDY+i] = dyv[k]; end
            dwmem[BDW] = 32'h1234;
            run_job(1, 1, 2, 2, 1, 1, 2, 2, 1, 0, 1'b0, cyc, to);
            if (to !== 1'b0 || dwmem[BDW] !== ev[k]) begin
                $display("FAIL sat_case%0d got=%h timeout=%b want=%h", k, dwmem[BDW], to, ev[k]);
                bad++;
            end
            total++;
        end
        $display("test_saturate checked 3 cases");
    endtask

    task automatic test_reset_mid();
        int cyc; logic to; logic seen;
        int exp[4] = '{12, 16, 24, 28};
        load_t1(0);
        @(negedge clk);
        cfg = {DIMW'(1), DIMW'(1), DIMW'(3), DIMW'(3), DIMW'(2), DIMW'(2),
               DIMW'(2), DIMW'(2), DIMW'(1), DIMW'(0)};
        cfg_accum = 1'b0; go = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            go = 1'b0;
            if (x_req) begin seen = 1'b1; break; end
        end
        if (seen !== 1'b1 || busy !== 1'b1) begin
            $display("FAIL mid_load_reached seen=%b busy=%b want 1/1", seen, busy); bad++;
        end
        total++;
        rst_l = 1'b0;
        #1;
        if ({x_req, dy_req, busy} !== 3'b000) begin
            $display("FAIL mid_reset_drop got=%b want=000", {x_req, dy_req, busy}); bad++;
        end
        total++;
        @(negedge clk); @(negedge clk);
        rst_l = 1'b1;
        run_job(1, 1, 3, 3, 2, 2, 2, 2, 1, 0, 1'b0, cyc, to);
        if (to !== 1'b0) begin $display("FAIL mid_rerun_timeout got=%b want=0", to); bad++; end
        total++;
        for (int i = 0; i < 4; i++) begin
            if (dwmem[BDW+i] !== DW'(exp[i])) begin
                $display("FAIL mid_dw[%0d] got=%0d want=%0d", i, dwmem[BDW+i], exp[i]); bad++;
            end
            total++;
        end
        $display("test_reset_mid rerun done in %0d cycles", cyc);
    endtask

    task automatic test_zero_dim();
        int cyc; logic to;
        clear_counts();
        run_job(1, 0, 3, 3, 2, 2, 2, 2, 1, 0, 1'b0, cyc, to);
        if (to !== 1'b0 || cyc !== 2) begin
            $display("FAIL zero_done_latency got=%0d timeout=%b want=2", cyc, to); bad++;
        end
        total++;
        if (req_seen !== 0) begin
            $display("FAIL zero_no_req got=%0d want=0", req_seen); bad++;
        end
        total++;
        $display("test_zero_dim done after %0d cycles", cyc);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_accum();
        test_pad_stride();
        test_random_ack();
        test_saturate();
        test_reset_mid();
        test_zero_dim();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
